fp_unit_arbiter: RTL
====================

Name: fp_unit_arbiter

Overview:
- Shares one pipelined single-precision FP unit (fadd/fsub/fmul-style port set: a, b, go, pipeEn, result, rdy) between NUM_REQ requesters.
- Round-robin arbitration; one operation issued per enabled cycle.
- Each in-flight op is tagged with its requester ID in an in-order tag FIFO; every result is routed back to its originator.
- Sits between kernel datapath stages and a shared FP operator instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width, equal to clog2(NUM_REQ)
- TAG_DEPTH, 16, max in-flight ops (power of 2, ≥ unit latency + 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pipeEn  in  1  global pipeline enable; 0 freezes the arbiter and the unit
- req  in  NUM_REQ  request per requester, level; held until granted
- a_in  in  32*NUM_REQ  operand A, requester i at bits [32i+31:32i]
- b_in  in  32*NUM_REQ  operand B, same packing as a_in
- grant  out  NUM_REQ  one-hot, combinational; op accepted this cycle
- resp_valid  out  NUM_REQ  one-hot, registered, 1-cycle pulse: result for requester i
- resp_data  out  32  result value, valid with resp_valid
- fu_a  out  32  to unit a
- fu_b  out  32  to unit b
- fu_go  out  1  to unit go
- fu_pipeEn  out  1  to unit pipeEn; equals pipeEn
- fu_result  in  32  from unit result
- fu_rdy  in  1  from unit rdy
- busy  out  1  any op pending in the issue register or the tag FIFO
- err  out  1  sticky: fu_rdy seen with tag FIFO empty

Behaviour:
- Reset (async, rst_n=0):
  - grant=0, resp_valid=0, resp_data=0, fu_a=0, fu_b=0, fu_go=0, busy=0, err=0.
  - Tag FIFO emptied; RR pointer=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation discards all in-flight tags. Results the unit delivers after reset are counted as underflow and set err.
- Issue is allowed when pipeEn=1 and the tag FIFO is not full (count < TAG_DEPTH).
- Arbitration:
  - When issue is allowed, grant the first requester with req=1, searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - grant is combinational from req, the pointer and the FIFO count.
  - No grant when issue is not allowed.
  - On a grant to i, ptr<=i. With no grant, ptr holds.
- Issue register, updated only when pipeEn=1:
  - fu_go<=|grant.
  - On a grant: fu_a<=a_in[i], fu_b<=b_in[i]. Otherwise fu_a and fu_b hold.
  - When pipeEn=0, all issue registers hold. Because the unit samples only with ce high, each issue is seen exactly once.
- Tag FIFO:
  - Push i in the grant cycle.
  - Pop when fu_rdy=1 and pipeEn=1.
  - A simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo TAG_DEPTH.
  - Full (count=TAG_DEPTH) blocks grants; a pop in the same cycle does not unblock, because the full check uses the registered count.
- Response:
  - When fu_rdy=1 and pipeEn=1 with the FIFO non-empty: at the next edge resp_valid<=onehot(head tag) and resp_data<=fu_result.
  - Otherwise resp_valid<=0 and resp_data holds.
  - fu_rdy with pipeEn=0 is ignored, so a frozen rdy is never counted twice.
- Underflow: fu_rdy=1 and pipeEn=1 with the FIFO empty sets err=1, no pop, no response. err is cleared only by reset.
- Latency:
  - Grant at cycle t gives fu_go=1 in cycle t+1.
  - Unit latency is L (rdy at t+1+L), so resp_valid is seen in cycle t+2+L (all with pipeEn=1).
  - Every pipeEn=0 cycle adds one cycle.
- Ordering: results return in issue order; requesters receive them in their own issue order.
- busy = fu_go | (FIFO count != 0).

Test Plan:
- Single request: req[2]=1 at t with a=0x3F800000, b=0x40000000, L=8 (fadd) -> grant[2] at t, fu_go at t+1, resp_valid=0100 with resp_data=0x40400000 at t+10.
- All four requesters held high for 8 cycles -> grants rotate 0,1,2,3,0,1,2,3; responses arrive in the same order, each carrying the correct sum.
- pipeEn low for 3 cycles while fu_go=1 and results are in flight -> no new grant, fu_a and fu_b hold, no duplicate or lost results; response times shift by 3 cycles.
- TAG_DEPTH=4 with unit latency 8 and continuous req[0] -> 4 grants, then grant=0 until the first pop; 4 in flight at most; all results delivered.
- fu_rdy forced high with the FIFO empty -> err=1 and stays set, resp_valid=0; rst_n low mid-stream -> all outputs 0 immediately, asynchronously.
- Simultaneous grant and result pop at full-minus-one -> count unchanged, correct tag routed, no gap or repeat.

Source files
------------

// File: rtl/fp_unit_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fp_unit_arbiter_if
//  Purpose  : Bundles the requester-side and FP-unit-side signals of the
//             shared FP unit arbiter.
//  Modports : master - surrounding system (requesters plus the FP unit)
//             slave  - the arbiter itself
//  Signals  : pipeEn, req, a_in, b_in     requester/pipeline -> arbiter
//             grant, resp_valid, resp_data arbiter -> requesters
//             fu_a, fu_b, fu_go, fu_pipeEn arbiter -> FP unit
//             fu_result, fu_rdy            FP unit -> arbiter
//             busy, err                    status
//  Revision : 1.0  initial release
// ============================================================================
interface fp_unit_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic                   pipeEn;
  logic [NUM_REQ-1:0]     req;
  logic [32*NUM_REQ-1:0]  a_in;
  logic [32*NUM_REQ-1:0]  b_in;
  logic [NUM_REQ-1:0]     grant;
  logic [NUM_REQ-1:0]     resp_valid;
  logic [31:0]            resp_data;
  logic [31:0]            fu_a;
  logic [31:0]            fu_b;
  logic                   fu_go;
  logic                   fu_pipeEn;
  logic [31:0]            fu_result;
  logic                   fu_rdy;
  logic                   busy;
  logic                   err;

  modport master (
    output pipeEn, req, a_in, b_in, fu_result, fu_rdy,
    input  grant, resp_valid, resp_data, fu_a, fu_b, fu_go, fu_pipeEn,
           busy, err
  );

  modport slave (
    input  pipeEn, req, a_in, b_in, fu_result, fu_rdy,
    output grant, resp_valid, resp_data, fu_a, fu_b, fu_go, fu_pipeEn,
           busy, err
  );
endinterface
`default_nettype wire

// File: rtl/fp_unit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fp_unit_arbiter
//  Purpose  : Shares one pipelined single-precision FP unit between NUM_REQ
//             requesters. Round-robin arbitration issues at most one op per
//             enabled cycle; each issued op's requester ID is queued in an
//             in-order tag FIFO so every result returns to its originator.
//  Ports    : clk    - clock
//             rst_n  - asynchronous active-low reset
//             bus    - fp_unit_arbiter_if.slave (requests, grants, responses,
//                      FP unit operands/results, busy and sticky err)
//  Params   : NUM_REQ   number of requesters (2..8)
//             ID_W      requester ID width, clog2(NUM_REQ)
//             TAG_DEPTH max in-flight ops (power of 2)
//  Revision : 1.0  initial release
// ============================================================================
module fp_unit_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int TAG_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_unit_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   tag_count;
  logic [ID_W-1:0]    head_tag;

  logic               fifo_full;
  logic               fifo_empty;
  logic               issue_ok;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] grant_vec;
  logic               push;
  logic               pop_req;
  logic               pop;

  // Full uses the registered count only, so a pop in the same cycle does
  // not reopen issue until the next cycle.
  assign fifo_full  = (tag_count == CNT_W'(TAG_DEPTH));
  assign fifo_empty = (tag_count == '0);
  // rst_n gates the combinational grant so it reads 0 while in reset.
  assign issue_ok   = rst_n & bus.pipeEn & ~fifo_full;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    logic [ID_W-1:0] cand;
    grant_any = 1'b0;
    grant_id  = '0;
    grant_vec = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (issue_ok && !grant_any && bus.req[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    if (grant_any) begin
      grant_vec[grant_id] = 1'b1;
    end
  end

  assign bus.grant     = grant_vec;
  assign bus.fu_pipeEn = bus.pipeEn;
  assign bus.busy      = bus.fu_go | ~fifo_empty;

  assign push     = grant_any;
  // A frozen rdy (pipeEn=0) is ignored so the same result is never taken twice.
  assign pop_req  = bus.fu_rdy & bus.pipeEn;
  assign pop      = pop_req & ~fifo_empty;
  assign head_tag = tag_mem[rd_ptr];

  // Tag storage needs no reset; the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= ID_W'(NUM_REQ - 1);
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      tag_count      <= '0;
      bus.fu_go      <= 1'b0;
      bus.fu_a       <= '0;
      bus.fu_b       <= '0;
      bus.resp_valid <= '0;
      bus.resp_data  <= '0;
      bus.err        <= 1'b0;
    end else begin
      // Issue register: held while the pipeline is frozen so the unit,
      // which only samples with ce high, sees each op exactly once.
      if (bus.pipeEn) begin
        bus.fu_go <= grant_any;
        if (grant_any) begin
          bus.fu_a <= bus.a_in[32*int'(grant_id) +: 32];
          bus.fu_b <= bus.b_in[32*int'(grant_id) +: 32];
        end
      end

      if (grant_any) begin
        rr_ptr <= grant_id;
      end

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   tag_count <= tag_count + CNT_W'(1);
        2'b01:   tag_count <= tag_count - CNT_W'(1);
        default: tag_count <= tag_count;
      endcase

      if (pop) begin
        bus.resp_valid <= NUM_REQ'(1) << head_tag;
        bus.resp_data  <= bus.fu_result;
      end else begin
        bus.resp_valid <= '0;
      end

      // A result with no outstanding tag cannot be routed; flag it.
      if (pop_req && fifo_empty) begin
        bus.err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
